mux_nsel_reg: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes and two selection modes: fixed (external select) and round-robin (automatic fair scan). It extends the 2:1 combinational mux into a clocked channel selector that feeds a single downstream consumer. The block holds at most one word in an output register, so backpressure from the consumer propagates back to the granted channel.

---
 rtl/mux_nsel_reg.sv | 116 +++++++++++
 tb/tb_mux_nsel_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nsel_reg.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Selects either a fixed channel or a round-robin channel into a single output register.
module mux_nsel_reg #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [WIDTH-1:0]      out_data_q, out_data_d;
   logic [SEL_W-1:0]      out_ch_q, out_ch_d;
   logic                  out_valid_q, out_valid_d;
   logic [SEL_W-1:0]      ptr_q, ptr_d;

   logic                  grant_vld;
   logic [SEL_W-1:0]      grant_idx;
   logic [WIDTH-1:0]      grant_data;
   logic                  can_load;
   logic                  xfer;
   logic [2*CHANNELS-1:0] rr_dbl;
   logic [2*CHANNELS-1:0] rr_rot;
   int                    rr_idx;

   // Round-robin rotates the doubled valid vector so bit 0 is the channel just after ptr.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_idx    = 0;
      rr_dbl    = {in_valid, in_valid};
      rr_rot    = rr_dbl >> (32'(ptr_q) + 32'd1);
      if (!mode) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_W'(i);
            end
         end
      end else begin
         for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (rr_rot[j]) begin
               grant_vld = 1'b1;
               rr_idx    = int'(ptr_q) + 1 + j;
            end
         end
         if (rr_idx >= CHANNELS) begin
            rr_idx = rr_idx - CHANNELS;
         end
         grant_idx = SEL_W'(rr_idx);
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign can_load = !out_valid_q || out_ready;
   assign xfer     = grant_vld && can_load && !rst;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = xfer && (grant_idx == SEL_W'(i));
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = grant_data;
         out_ch_d    = grant_idx;
         out_valid_d = 1'b1;
         ptr_d       = grant_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Reset parks ptr on the last channel so the first round-robin scan starts at channel 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= SEL_W'(CHANNELS - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nsel_reg.sv
// Self-checking bench for mux_nsel_reg: random traffic against a distance-based
// arbitration model (4 channels) plus directed checks, including a 3-channel instance.
module tb_mux_nsel_reg;

   logic        clk;
   logic        rst;

   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic [23:0] u3_data;
   logic [2:0]  u3_valid;
   logic [2:0]  u3_ready;
   logic        u3_mode;
   logic [1:0]  u3_sel;
   logic [7:0]  u3_odata;
   logic [1:0]  u3_och;
   logic        u3_ovalid;
   logic        u3_oready;

   int checks = 0;
   int errors = 0;

   mux_nsel_reg #(.WIDTH(8), .CHANNELS(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_nsel_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
      .clk(clk), .rst(rst), .in_data(u3_data), .in_valid(u3_valid), .in_ready(u3_ready),
      .mode(u3_mode), .sel(u3_sel), .out_data(u3_odata), .out_ch(u3_och),
      .out_valid(u3_ovalid), .out_ready(u3_oready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: sampled at the falling edge, where inputs and outputs are stable.
   initial begin : compare
      logic       m_valid;
      logic [7:0] m_data;
      int         m_ch;
      int         m_ptr;
      int         g;
      int         best;
      int         d;
      logic [3:0] exp_rdy;
      bit         can;
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 3;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 3;
         end
         g = -1;
         if (!mode) begin
            if (int'(sel) < 4 && in_valid[sel]) g = int'(sel);
         end else begin
            best = 4;
            for (int i = 0; i < 4; i++) begin
               if (in_valid[i]) begin
                  d = (i - m_ptr - 1 + 8) % 4;
                  if (d < best) begin
                     best = d;
                     g = i;
                  end
               end
            end
         end
         can = !m_valid || out_ready;
         exp_rdy = (!rst && g >= 0 && can) ? 4'(1 << g) : 4'b0000;
         chk("m_out_valid", 32'(out_valid), 32'(m_valid));
         chk("m_out_data", 32'(out_data), 32'(m_data));
         chk("m_out_ch", 32'(out_ch), 32'(m_ch));
         chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
         if (!rst) begin
            if (g >= 0 && can) begin
               m_valid = 1'b1;
               m_data  = in_data[g*8 +: 8];
               m_ch    = g;
               m_ptr   = g;
            end else if (out_ready) begin
               m_valid = 1'b0;
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] snap_data;
      logic [1:0] snap_ch;
      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      u3_data = 24'h33_C3_11; u3_valid = 3'b111; u3_mode = 1'b0; u3_sel = 2'd1; u3_oready = 1'b0;

      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;

      // Fixed select of channel 2
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h44_A5_22_11; out_ready = 1'b1;
      #1;
      chk("fixed_in_ready", 32'(in_ready), 32'h4);
      tick();
      chk("fixed_out_data", 32'(out_data), 32'hA5);
      chk("fixed_out_ch", 32'(out_ch), 32'd2);
      chk("fixed_out_valid", 32'(out_valid), 32'd1);

      // Asynchronous reset while a word is held
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", 32'(out_data), 32'd0);
      chk("async_rst_ch", 32'(out_ch), 32'd0);
      chk("async_rst_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;

      // Round-robin fairness with all channels valid
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_out_ch", 32'(out_ch), 32'(k % 4));
         chk("rr_out_valid", 32'(out_valid), 32'd1);
      end

      // Sparse round-robin: ch1 then alternate 3,1
      in_valid = 4'b0010;
      #1;
      chk("sparse_first_ready", 32'(in_ready), 32'h2);
      tick();
      chk("sparse_first_ch", 32'(out_ch), 32'd1);
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("sparse_ch", 32'(out_ch), (k % 2 == 0) ? 32'd3 : 32'd1);
      end

      // Backpressure: hold for 3 cycles then drain and load together
      in_valid = 4'b1111; out_ready = 1'b0; in_data = 32'h0D_0C_0B_0A;
      snap_data = out_data; snap_ch = out_ch;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
         chk("bp_out_ch", 32'(out_ch), 32'(snap_ch));
         chk("bp_out_data", 32'(out_data), 32'(snap_data));
         chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'h4);
      tick();
      chk("bp_release_ch", 32'(out_ch), 32'd2);
      chk("bp_release_data", 32'(out_data), 32'h0C);
      chk("bp_release_valid", 32'(out_valid), 32'd1);

      // Randomized traffic with occasional reset
      for (int n = 0; n < 1500; n++) begin
         tick();
         rst       = ($urandom_range(0, 99) == 0);
         mode      = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      rst = 1'b0;
      tick();
      tick();

      // Three-channel instance: out-of-range select never grants
      chk("c3_loaded_valid", 32'(u3_ovalid), 32'd1);
      chk("c3_loaded_ch", 32'(u3_och), 32'd1);
      chk("c3_loaded_data", 32'(u3_odata), 32'hC3);
      u3_sel = 2'd3;
      #1;
      chk("c3_sel3_ready_full", 32'(u3_ready), 32'd0);
      u3_oready = 1'b1;
      #1;
      chk("c3_sel3_ready_drain", 32'(u3_ready), 32'd0);
      tick();
      chk("c3_drained_valid", 32'(u3_ovalid), 32'd0);
      chk("c3_drained_ch", 32'(u3_och), 32'd1);
      chk("c3_drained_ready", 32'(u3_ready), 32'd0);
      tick();
      chk("c3_still_empty", 32'(u3_ovalid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
